// File: rtl/mem_scan_reader_if.sv
// Signal bundle between the RAM read sequencer and the RAM / display side.
// The master modport is the sequencer itself; the slave modport is the side
// that supplies control levels and RAM read data and consumes the outputs.
interface mem_scan_reader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4,
   parameter int SUM_W  = ADDR_W + DATA_W
);
   logic              Start;
   logic              Stop;
   logic              Continuous;
   logic [ADDR_W-1:0] RamAddr;
   logic [DATA_W-1:0] RamData;
   logic [ADDR_W-1:0] CurAddr;
   logic [DATA_W-1:0] CurData;
   logic              Valid;
   logic              Busy;
   logic              Done;
   logic [SUM_W-1:0]  Checksum;

   modport master (
      input  Start, Stop, Continuous, RamData,
      output RamAddr, CurAddr, CurData, Valid, Busy, Done, Checksum
   );

   modport slave (
      output Start, Stop, Continuous, RamData,
      input  RamAddr, CurAddr, CurData, Valid, Busy, Done, Checksum
   );
endinterface

// File: rtl/mem_scan_reader.sv
// Read-side sequencer for the synchronous-read RAM: sweeps every address,
// captures each word one cycle after the RAM registers its address, holds it
// for DWELL cycles for display, and keeps a per-pass checksum.
module mem_scan_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4,
   parameter int DWELL  = 50_000_000,
   parameter int SUM_W  = ADDR_W + DATA_W
) (
   input logic             Clock,
   input logic             Resetn,
   mem_scan_reader_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_DWELL,
      S_DONE
   } state_t;

   // Counter only needs to hold DWELL-1; keep at least one bit for DWELL=1.
   localparam int                CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(DWELL - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [DATA_W-1:0]   cur_data_q, cur_data_d;
   logic                valid_q, valid_d;
   logic                done_q, done_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [SUM_W-1:0]    chk_q, chk_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // Next-state and datapath updates; Stop outranks everything once running.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cur_addr_d = cur_addr_q;
      cur_data_d = cur_data_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      sum_d      = sum_q;
      chk_d      = chk_q;
      cnt_d      = cnt_q;

      if (state_q != S_IDLE && bus.Stop) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.Start && !bus.Stop) begin
                  state_d = S_ISSUE;
                  addr_d  = '0;
                  sum_d   = '0;
                  valid_d = 1'b0;
               end
            end
            // RAM registers addr_q at the edge leaving this state.
            S_ISSUE: begin
               state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
               cur_data_d = bus.RamData;
               cur_addr_d = addr_q;
               sum_d      = sum_q + SUM_W'(bus.RamData);
               valid_d    = 1'b1;
               cnt_d      = CNT_LOAD;
               state_d    = S_DWELL;
            end
            S_DWELL: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (addr_q != LAST_ADDR) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = S_ISSUE;
               end else begin
                  // End of pass: sum already contains word 31.
                  chk_d  = sum_q;
                  sum_d  = '0;
                  done_d = 1'b1;
                  if (bus.Continuous) begin
                     addr_d  = '0;
                     state_d = S_ISSUE;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         cur_addr_q <= '0;
         cur_data_q <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         sum_q      <= '0;
         chk_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cur_addr_q <= cur_addr_d;
         cur_data_q <= cur_data_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         sum_q      <= sum_d;
         chk_q      <= chk_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.RamAddr  = addr_q;
   assign bus.CurAddr  = cur_addr_q;
   assign bus.CurData  = cur_data_q;
   assign bus.Valid    = valid_q;
   assign bus.Busy     = (state_q != S_IDLE);
   assign bus.Done     = done_q;
   assign bus.Checksum = chk_q;

endmodule
